// File: rtl/sfx_pkg.sv
// Shared definitions for the whack-a-mole sound-effect player:
// event encoding, sequencer states and the tone ROM.
package sfx_pkg;

    typedef enum logic [1:0] {
        EVT_NONE     = 2'd0,
        EVT_HIT      = 2'd1,
        EVT_MISS     = 2'd2,
        EVT_GAMEOVER = 2'd3
    } evt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    localparam int unsigned SEQ_LEN_MAX = 8;
    localparam int unsigned IDX_W       = 3;

    // Pre-emption rank: game over beats hit, hit beats miss.
    function automatic logic [1:0] evt_rank(input evt_e evt);
        logic [1:0] r;
        case (evt)
            EVT_GAMEOVER: r = 2'd3;
            EVT_HIT:      r = 2'd2;
            EVT_MISS:     r = 2'd1;
            default:      r = 2'd0;
        endcase
        return r;
    endfunction

    // Half-period divisors at 50 MHz; zero marks a rest.
    function automatic logic [15:0] tone_div(input evt_e evt, input logic [IDX_W-1:0] idx);
        logic [15:0] d;
        d = '0;
        case (evt)
            EVT_HIT: begin
                case (idx)
                    3'd0:    d = 16'd23889;
                    3'd1:    d = 16'd18961;
                    default: d = '0;
                endcase
            end
            EVT_MISS: begin
                case (idx)
                    3'd0:    d = 16'd56818;
                    3'd2:    d = 16'd56818;
                    default: d = '0;
                endcase
            end
            EVT_GAMEOVER: begin
                case (idx)
                    3'd0:    d = 16'd31888;
                    3'd1:    d = 16'd37920;
                    3'd2:    d = 16'd47778;
                    3'd3:    d = 16'd47778;
                    default: d = '0;
                endcase
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave generator: toggles tone every div cycles, held low on rest
// and cleared on restart.
module sfx_tone_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    input  logic             rest,
    output logic             tone
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    // Half-period counter and toggle decision.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart || rest) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (cnt_q == div - DIV_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter and tone registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/sfx_buzzer.sv
// Note-sequence sound-effect player: decodes hit/miss/game-over events with
// priority pre-emption and one hit sound per mole, steps through the melody
// notes and drives the buzzer pin.
module sfx_buzzer
    import sfx_pkg::*;
#(
    parameter int unsigned NOTE_TICKS   = 5_000_000,
    parameter int unsigned SEQ_LEN      = 4,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DUR_W        = 24,
    parameter int unsigned DIV_SCALE_SH = 0
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       new_mole,
    input  logic       hit,
    input  logic       miss,
    input  logic       game_over,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [1:0] evt_id,
    output logic       done
);

    state_e             state_q, state_d;
    evt_e               evt_q, evt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic               armed_q, armed_d;
    logic               hit_q, hit_d;
    logic               done_q, done_d;

    logic               hit_acc;
    evt_e               cand;
    logic               playing;
    logic               note_end;
    logic               completing;
    logic               start;

    logic [15:0]        rom_div;
    logic [15:0]        div_shift;
    logic [DIV_W-1:0]   div;
    logic               tone_restart;
    logic               tone_rest;
    logic               tone;

    // State and sequencer registers.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            evt_q   <= EVT_NONE;
            idx_q   <= '0;
            dur_q   <= '0;
            armed_q <= 1'b1;
            hit_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            armed_q <= armed_d;
            hit_q   <= hit_d;
            done_q  <= done_d;
        end
    end

    // Trigger arbitration, pre-emption and note stepping.
    always_comb begin
        hit_acc = hit & ~hit_q & armed_q;

        cand = EVT_NONE;
        if (game_over)    cand = EVT_GAMEOVER;
        else if (hit_acc) cand = EVT_HIT;
        else if (miss)    cand = EVT_MISS;

        playing    = (state_q == ST_PLAY);
        note_end   = playing && (dur_q == DUR_W'(NOTE_TICKS - 1));
        completing = note_end && (idx_q == IDX_W'(SEQ_LEN - 1));
        // A trigger landing on the completion edge chains directly, whatever its rank.
        start      = (cand != EVT_NONE) &&
                     (!playing || completing || (evt_rank(cand) > evt_rank(evt_q)));

        state_d = state_q;
        evt_d   = evt_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        done_d  = completing;
        hit_d   = hit;

        // An accepted hit consumes the arm even when it loses arbitration.
        if (new_mole)     armed_d = 1'b1;
        else if (hit_acc) armed_d = 1'b0;
        else              armed_d = armed_q;

        if (start) begin
            state_d = ST_PLAY;
            evt_d   = cand;
            idx_d   = '0;
            dur_d   = '0;
        end else if (completing) begin
            state_d = ST_IDLE;
            evt_d   = EVT_NONE;
            idx_d   = '0;
            dur_d   = '0;
        end else if (note_end) begin
            idx_d = idx_q + IDX_W'(1);
            dur_d = '0;
        end else if (playing) begin
            dur_d = dur_q + DUR_W'(1);
        end
    end

    // Outputs and tone generator control for the current note.
    always_comb begin
        busy         = (state_q == ST_PLAY);
        evt_id       = evt_q;
        done         = done_q;
        rom_div      = tone_div(evt_q, idx_q);
        div_shift    = rom_div >> DIV_SCALE_SH;
        if ((rom_div != 16'd0) && (div_shift == 16'd0)) div_shift = 16'd1;
        div          = DIV_W'(div_shift);
        tone_restart = start || note_end;
        tone_rest    = (state_q != ST_PLAY) || (rom_div == 16'd0);
        beep         = tone & ~mute;
    end

    sfx_tone_gen #(
        .DIV_W(DIV_W)
    ) u_tone_gen (
        .clk     (clk_50),
        .rst     (rst),
        .div     (div),
        .restart (tone_restart),
        .rest    (tone_rest),
        .tone    (tone)
    );

endmodule
